inst_encoder: RTL and testbench
===============================

Name: inst_encoder

Overview:
- Encodes RV32 R/I/S/B instruction fields plus a signed immediate into a 32-bit instruction word, performing the inverse of imm_generator.
- Sits between the test-program loader or assembler front end and instruction memory.
- Emits each encoded word with a byte write address.
- Single-entry registered output with valid/ready handshake on both sides. Illegal immediates are rejected and counted.

Parameters:
ADDR_W, 8, width of out_addr (byte address); wraps modulo 2^ADDR_W
ERR_W, 8, width of saturating error counter

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  reset, synchronous, active-low
in_valid  input  1  input fields valid
in_ready  output  1  encoder can accept this cycle
in_opcode  input  7  opcode field Inst[6:0]
in_rd  input  5  destination register
in_funct3  input  3  funct3
in_rs1  input  5  source register 1
in_rs2  input  5  source register 2
in_funct7  input  7  funct7 (R-type only)
in_imm  input  32  signed immediate; byte offset for B-type
out_valid  output  1  out_inst/out_addr valid
out_ready  input  1  consumer accepts output
out_inst  output  32  encoded instruction
out_addr  output  ADDR_W  byte address for out_inst
err  output  1  one-cycle pulse: last accepted input was illegal
err_cnt  output  ERR_W  saturating count of rejected inputs

Behaviour:
- Reset (rst==0 at a clock edge):
  - out_valid=0, out_inst=0, out_addr=0, err=0, err_cnt=0.
  - Any pending output is discarded.
  - in_ready is low during the reset cycle.
- Format select, first match wins:
  - opcode==7'b0110011 → R.
  - opcode[6]==1 → B.
  - opcode[5]==0 → I.
  - else → S.
- Encoding:
  - R = {funct7, rs2, rs1, funct3, rd, opcode}.
  - I = {imm[11:0], rs1, funct3, rd, opcode}.
  - S = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
  - B = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}.
  - Unused fields for a format are ignored (e.g. rd for S/B, rs2 for I).
- Legality:
  - I/S: in_imm must lie in -2048..2047.
  - B: in_imm must be even and lie in -4096..4094.
  - R: in_imm is ignored.
  - Violations are illegal.
- Handshake:
  - in_ready = rst & (!out_valid | out_ready). This gives one accept per cycle sustained.
  - Accept = in_valid & in_ready.
  - An output transfer occurs on out_valid & out_ready.
- Per cycle, when out of reset:
  - Legal accept: out_inst <= encoding and out_valid <= 1, next cycle. Latency is 1 cycle.
  - Illegal accept:
    - err <= 1 next cycle; err_cnt <= err_cnt+1, saturating at all-ones.
    - Nothing is emitted.
    - out_valid <= 0 if a transfer occurs this cycle, else it holds.
    - out_addr is unchanged by the rejection.
  - No accept and a transfer occurs: out_valid <= 0.
  - err is 0 in every cycle not following an illegal accept.
- Address:
  - out_addr advances by 4 on every output transfer.
  - It wraps from 2^ADDR_W-4 to 0.
  - A transfer and a new accept in the same cycle are both honoured: the new word appears with the incremented address.
- Stall: while out_valid & !out_ready, out_inst and out_addr hold stable and in_ready is 0.
- States:
  - EMPTY (out_valid=0).
  - FULL (out_valid=1).
  - EMPTY→FULL on a legal accept.
  - FULL→EMPTY on a transfer without a legal accept.
  - FULL→FULL on stall, or on a transfer plus a legal accept.

Test Plan:
- Encoding checks:
  - addi x1,x0,5 (opcode 0010011, f3 000, rd 1, rs1 0, imm 5) → out_inst 0x00500093, out_addr 0x00, latency 1 cycle.
  - sw x2,8(x1) (0100011, f3 010, rs1 1, rs2 2, imm 8) → 0x0020A423.
  - beq x1,x2,-4 (1100011, f3 000, imm -4) → 0xFE208EE3.
  - add x3,x1,x2 (0110011, f7 0, f3 0) → 0x002081B3.
- Illegal immediates:
  - addi with imm 2048 → err pulses one cycle, err_cnt=1, out_valid stays 0, next legal word still gets out_addr 0x00.
  - beq with imm 3 → same response.
  - beq with imm 4096 → same response.
- Throughput and back-pressure:
  - Stream 4 legal words with out_ready=1 → one word per cycle, out_addr 0x00, 0x04, 0x08, 0x0C.
  - Drop out_ready for 3 cycles mid-stream → in_ready=0 and out_inst/out_addr held stable.
- Wrap: with ADDR_W=4, issue 5 transfers → out_addr sequence 0x0, 0x4, 0x8, 0xC, 0x0.
- Reset mid-stall: with out_valid=1 and out_ready=0, assert rst low one cycle → out_valid=0, out_addr=0, err_cnt=0, in_ready=0 during reset.
- err_cnt saturation: 300 illegal inputs with ERR_W=8 → err_cnt holds 0xFF.

Source files
------------

// File: rtl/inst_encoder_if.sv
// rtl/inst_encoder_if.sv - instruction field input and encoded word output handshake bundle
interface inst_encoder_if #(
    parameter int ADDR_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [6:0]        in_opcode;
    logic [4:0]        in_rd;
    logic [2:0]        in_funct3;
    logic [4:0]        in_rs1;
    logic [4:0]        in_rs2;
    logic [6:0]        in_funct7;
    logic [31:0]       in_imm;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_inst;
    logic [ADDR_W-1:0] out_addr;

    modport master (
        output in_valid, in_opcode, in_rd, in_funct3, in_rs1, in_rs2, in_funct7, in_imm,
        input  in_ready,
        input  out_valid, out_inst, out_addr,
        output out_ready
    );

    modport slave (
        input  in_valid, in_opcode, in_rd, in_funct3, in_rs1, in_rs2, in_funct7, in_imm,
        output in_ready,
        output out_valid, out_inst, out_addr,
        input  out_ready
    );
endinterface

// File: rtl/inst_encoder.sv
// rtl/inst_encoder.sv - RV32 R/I/S/B field encoder with single-entry registered output
module inst_encoder #(
    parameter int ADDR_W = 8,
    parameter int ERR_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    inst_encoder_if.slave    bus,
    output logic             err,
    output logic [ERR_W-1:0] err_cnt
);
    typedef enum logic { EMPTY, FULL } state_t;
    typedef enum logic [1:0] { FMT_R, FMT_I, FMT_S, FMT_B } fmt_t;

    state_t            state;
    logic [31:0]       inst_q;
    logic [ADDR_W-1:0] addr_q;

    fmt_t               fmt;
    logic [31:0]        enc;
    logic               legal;
    logic signed [31:0] simm;
    logic               accept;
    logic               xfer;

    assign simm = $signed(bus.in_imm);

    always_comb begin
        fmt = FMT_S;
        if (bus.in_opcode == 7'b0110011) begin
            fmt = FMT_R;
        end else if (bus.in_opcode[6]) begin
            fmt = FMT_B;
        end else if (!bus.in_opcode[5]) begin
            fmt = FMT_I;
        end
    end

    always_comb begin
        enc   = 32'd0;
        legal = 1'b1;
        case (fmt)
            FMT_R: enc = {bus.in_funct7, bus.in_rs2, bus.in_rs1, bus.in_funct3,
                          bus.in_rd, bus.in_opcode};
            FMT_I: begin
                enc   = {bus.in_imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, bus.in_opcode};
                legal = (simm >= -32'sd2048) && (simm <= 32'sd2047);
            end
            FMT_S: begin
                enc   = {bus.in_imm[11:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                         bus.in_imm[4:0], bus.in_opcode};
                legal = (simm >= -32'sd2048) && (simm <= 32'sd2047);
            end
            default: begin
                enc   = {bus.in_imm[12], bus.in_imm[10:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                         bus.in_imm[4:1], bus.in_imm[11], bus.in_opcode};
                // branch offsets are halfword-aligned, so bit 0 must be clear
                legal = !bus.in_imm[0] && (simm >= -32'sd4096) && (simm <= 32'sd4094);
            end
        endcase
    end

    assign bus.in_ready  = rst && ((state == EMPTY) || bus.out_ready);
    assign accept        = bus.in_valid && bus.in_ready;
    assign xfer          = (state == FULL) && bus.out_ready;
    assign bus.out_valid = (state == FULL);
    assign bus.out_inst  = inst_q;
    assign bus.out_addr  = addr_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= EMPTY;
            inst_q  <= 32'd0;
            addr_q  <= '0;
            err     <= 1'b0;
            err_cnt <= '0;
        end else begin
            err <= accept && !legal;
            if (accept && !legal && (err_cnt != {ERR_W{1'b1}})) begin
                err_cnt <= err_cnt + 1'b1;
            end
            if (xfer) begin
                addr_q <= addr_q + ADDR_W'(4);
            end
            case (state)
                EMPTY: begin
                    if (accept && legal) begin
                        state  <= FULL;
                        inst_q <= enc;
                    end
                end
                default: begin
                    if (accept && legal) begin
                        inst_q <= enc;
                    end else if (xfer) begin
                        state <= EMPTY;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_inst_encoder.sv
// tb/tb_inst_encoder.sv - randomized and directed bench for inst_encoder against a field-level model
module tb_inst_encoder;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       err;
    logic [7:0] err_cnt;
    logic       err4;
    logic [7:0] err_cnt4;

    int checks = 0;
    int errors = 0;

    inst_encoder_if #(.ADDR_W(8)) bus ();
    inst_encoder_if #(.ADDR_W(4)) bus4 ();

    inst_encoder #(.ADDR_W(8), .ERR_W(8)) dut (
        .clk(clk), .rst(rst), .bus(bus), .err(err), .err_cnt(err_cnt)
    );

    inst_encoder #(.ADDR_W(4), .ERR_W(8)) dut4 (
        .clk(clk), .rst(rst), .bus(bus4), .err(err4), .err_cnt(err_cnt4)
    );

    assign bus4.in_valid  = bus.in_valid;
    assign bus4.in_opcode = bus.in_opcode;
    assign bus4.in_rd     = bus.in_rd;
    assign bus4.in_funct3 = bus.in_funct3;
    assign bus4.in_rs1    = bus.in_rs1;
    assign bus4.in_rs2    = bus.in_rs2;
    assign bus4.in_funct7 = bus.in_funct7;
    assign bus4.in_imm    = bus.in_imm;
    assign bus4.out_ready = bus.out_ready;

    always #5 clk = ~clk;

    // reference state: output slot, number of completed transfers, error status
    bit          m_valid = 0;
    logic [31:0] m_inst  = 0;
    int          m_words = 0;
    bit          m_err   = 0;
    int          m_cnt   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int fmt_of(input int op);
        if (op == 'h33) return 0;
        if (op >= 64) return 3;
        if ((op & 32) == 0) return 1;
        return 2;
    endfunction

    function automatic bit legal_ref(input int op, input int imm);
        case (fmt_of(op))
            0: return 1;
            1, 2: return imm >= -2048 && imm <= 2047;
            default: return (imm % 2 == 0) && imm >= -4096 && imm <= 4094;
        endcase
    endfunction

    function automatic logic [31:0] enc_ref(input int op, input int rd, input int f3, input int rs1,
                                            input int rs2, input int f7, input int imm);
        int base;
        base = (rs1 << 15) | (f3 << 12) | op;
        case (fmt_of(op))
            0: return base | (f7 << 25) | (rs2 << 20) | (rd << 7);
            1: return base | ((imm & 'hfff) << 20) | (rd << 7);
            2: return base | (((imm >> 5) & 'h7f) << 25) | (rs2 << 20) | ((imm & 'h1f) << 7);
            default: return base | (((imm >> 12) & 1) << 31) | (((imm >> 5) & 'h3f) << 25)
                          | (rs2 << 20) | (((imm >> 1) & 'hf) << 8) | (((imm >> 11) & 1) << 7);
        endcase
    endfunction

    task automatic cyc(input bit r, input bit v, input int op, input int rd, input int f3,
                       input int rs1, input int rs2, input int f7, input int imm, input bit ordy);
        bit ready, acc, xfer, lg;
        @(negedge clk);
        rst           = r;
        bus.in_valid  = v;
        bus.in_opcode = op[6:0];
        bus.in_rd     = rd[4:0];
        bus.in_funct3 = f3[2:0];
        bus.in_rs1    = rs1[4:0];
        bus.in_rs2    = rs2[4:0];
        bus.in_funct7 = f7[6:0];
        bus.in_imm    = imm;
        bus.out_ready = ordy;
        #1;
        ready = r && (!m_valid || ordy);
        check("in_ready", {31'd0, bus.in_ready}, {31'd0, ready});
        check("in_ready4", {31'd0, bus4.in_ready}, {31'd0, ready});
        acc  = v && ready;
        xfer = m_valid && ordy;
        lg   = legal_ref(op & 'h7f, imm);
        @(posedge clk);
        #1;
        if (!r) begin
            m_valid = 0; m_inst = 0; m_words = 0; m_err = 0; m_cnt = 0;
        end else begin
            m_err = acc && !lg;
            if (m_err && m_cnt < 255) m_cnt++;
            if (xfer) m_words++;
            if (acc && lg) begin
                m_valid = 1;
                m_inst  = enc_ref(op & 'h7f, rd & 31, f3 & 7, rs1 & 31, rs2 & 31, f7 & 'h7f, imm);
            end else if (xfer) begin
                m_valid = 0;
            end
        end
        check("out_valid", {31'd0, bus.out_valid}, {31'd0, m_valid});
        check("out_inst", bus.out_inst, m_inst);
        check("out_addr", {24'd0, bus.out_addr}, (m_words * 4) % 256);
        check("out_addr4", {28'd0, bus4.out_addr}, (m_words * 4) % 16);
        check("err", {31'd0, err}, {31'd0, m_err});
        check("err4", {31'd0, err4}, {31'd0, m_err});
        check("err_cnt", {24'd0, err_cnt}, m_cnt);
        check("err_cnt4", {24'd0, err_cnt4}, m_cnt);
    endtask

    int imm_tab[14] = '{0, 5, -4, 2047, 2048, -2048, -2049, 4094, 4095, 4096, -4096, -4098, 3, 100000};
    int op_tab[6]   = '{'h33, 'h13, 'h03, 'h23, 'h63, 'h6f};

    initial begin
        bus.in_valid = 0; bus.in_opcode = 0; bus.in_rd = 0; bus.in_funct3 = 0;
        bus.in_rs1 = 0; bus.in_rs2 = 0; bus.in_funct7 = 0; bus.in_imm = 0; bus.out_ready = 0;

        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 'h13, 1, 0, 0, 0, 0, 5, 1);

        // illegal immediates right after reset must not consume an address
        cyc(1, 1, 'h13, 1, 0, 0, 0, 0, 2048, 1);
        check("err_cnt_after_2048", {24'd0, err_cnt}, 32'd1);
        cyc(1, 1, 'h63, 0, 0, 1, 2, 0, 3, 1);
        cyc(1, 1, 'h63, 0, 0, 1, 2, 0, 4096, 1);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        check("err_cnt_three", {24'd0, err_cnt}, 32'd3);

        cyc(1, 1, 'h13, 1, 0, 0, 0, 0, 5, 1);
        check("addi", bus.out_inst, 32'h00500093);
        check("addi_addr", {24'd0, bus.out_addr}, 32'h00);
        cyc(1, 1, 'h23, 0, 2, 1, 2, 0, 8, 1);
        check("sw", bus.out_inst, 32'h0020A423);
        check("sw_addr", {24'd0, bus.out_addr}, 32'h04);
        cyc(1, 1, 'h63, 0, 0, 1, 2, 0, -4, 1);
        check("beq", bus.out_inst, 32'hFE208EE3);
        check("beq_addr", {24'd0, bus.out_addr}, 32'h08);
        cyc(1, 1, 'h33, 3, 0, 1, 2, 0, 0, 1);
        check("add", bus.out_inst, 32'h002081B3);
        check("add_addr", {24'd0, bus.out_addr}, 32'h0C);

        // back-pressure: the pending word and address must hold
        for (int i = 0; i < 3; i++) cyc(1, 1, 'h13, 7, 0, 3, 0, 0, 9, 0);
        check("stall_inst", bus.out_inst, 32'h002081B3);
        check("stall_addr", {24'd0, bus.out_addr}, 32'h0C);
        cyc(1, 1, 'h13, 7, 0, 3, 0, 0, 9, 1);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);

        for (int i = 0; i < 500; i++) begin
            int op, imm;
            op  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 127)) : op_tab[$urandom_range(0, 5)];
            imm = ($urandom_range(0, 2) == 0) ? int'($urandom) : imm_tab[$urandom_range(0, 13)];
            cyc(1, $urandom_range(0, 3) != 0, op, $urandom_range(0, 31), $urandom_range(0, 7),
                $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 127), imm,
                $urandom_range(0, 3) != 0);
        end

        // reset while stalled
        cyc(1, 1, 'h13, 1, 0, 0, 0, 0, 5, 1);
        cyc(1, 1, 'h13, 2, 0, 0, 0, 0, 6, 0);
        cyc(0, 1, 'h13, 2, 0, 0, 0, 0, 6, 0);
        check("rst_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_addr", {24'd0, bus.out_addr}, 32'd0);
        check("rst_cnt", {24'd0, err_cnt}, 32'd0);

        for (int i = 0; i < 300; i++) cyc(1, 1, 'h13, 1, 0, 0, 0, 0, 5000, 1);
        check("err_cnt_sat", {24'd0, err_cnt}, 32'hFF);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
